// File: rtl/code_entry_if.sv
// code_entry_if: keypad-side inputs and access-control-side outputs of code_entry.
// master drives the keypad signals, slave is the code_entry block.
interface code_entry_if;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CODE_W  = 16;
  localparam int unsigned COUNT_W = 3;

  logic [DIGIT_W-1:0] digit_in;
  logic               digit_btn;
  logic               clear_btn;
  logic [CODE_W-1:0]  data_out;
  logic               data_load;
  logic [COUNT_W-1:0] digit_count;
  logic               busy;

  modport master (
    output digit_in, digit_btn, clear_btn,
    input  data_out, data_load, digit_count, busy
  );

  modport slave (
    input  digit_in, digit_btn, clear_btn,
    output data_out, data_load, digit_count, busy
  );
endinterface

// File: rtl/code_entry.sv
// code_entry: assembles four keypad digits into a 16-bit code and strobes it out.
// Define CODE_ENTRY_DEBOUNCE_EN to insert a per-button debounce filter after the synchronisers.
module code_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned LOAD_CYCLES     = 2
) (
  input logic         clk,
  input logic         rst,
  code_entry_if.slave bus
);

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned CODE_W    = 16;
  localparam int unsigned SHIFT_W   = CODE_W - DIGIT_W;
  localparam int unsigned COUNT_W   = 3;
  localparam int unsigned TMO_W     = 20;
  localparam int unsigned LOAD_W    = 4;
  localparam int unsigned NUM_BTN   = 2;
  localparam int unsigned BTN_DIGIT = 0;
  localparam int unsigned BTN_CLEAR = 1;

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, LOAD} state_t;

  logic [DIGIT_W-1:0] dig_s1, dig_s2;
  logic [NUM_BTN-1:0] btn_s1, btn_s2, btn_filt, btn_prev, btn_armed;
  logic [NUM_BTN-1:0] btn_stb_c;
  logic [1:0]         warm;

  // Synchronisers, edge detector, and arming so a button held through reset needs a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_s1    <= '0;
      dig_s2    <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_prev  <= '0;
      btn_armed <= '0;
      warm      <= '0;
    end else begin
      dig_s1    <= bus.digit_in;
      dig_s2    <= dig_s1;
      btn_s1    <= {bus.clear_btn, bus.digit_btn};
      btn_s2    <= btn_s1;
      btn_prev  <= btn_filt;
      warm      <= {warm[0], 1'b1};
      btn_armed <= btn_armed | ({NUM_BTN{warm[1]}} & ~btn_s2);
    end
  end

  assign btn_stb_c = btn_filt & ~btn_prev & btn_armed;

`ifdef CODE_ENTRY_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] db_cnt [NUM_BTN];

  // Filtered level follows the raw level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_filt <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if (btn_s2[i] == btn_filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_filt[i] <= btn_s2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = |8'(DEBOUNCE_CYCLES);
  assign btn_filt = btn_s2;
`endif

  logic               digit_stb_c, clear_stb_c;
  state_t             state;
  logic [SHIFT_W-1:0] shift_reg;
  logic [COUNT_W-1:0] count;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [LOAD_W-1:0]  load_cnt;
  logic [CODE_W-1:0]  data_out_q;
  logic               data_load_q;
  logic               busy_q;

  assign digit_stb_c = btn_stb_c[BTN_DIGIT];
  assign clear_stb_c = btn_stb_c[BTN_CLEAR];

  // Entry FSM; shift_reg holds the first three digits, the fourth goes straight into data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      count       <= '0;
      tmo_cnt     <= '0;
      load_cnt    <= '0;
      data_out_q  <= '0;
      data_load_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (digit_stb_c) begin
            shift_reg <= {shift_reg[SHIFT_W-DIGIT_W-1:0], dig_s2};
            count     <= COUNT_W'(1);
            tmo_cnt   <= '0;
            busy_q    <= 1'b1;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (clear_stb_c) begin
            shift_reg <= '0;
            count     <= '0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end else if (digit_stb_c) begin
            shift_reg <= {shift_reg[SHIFT_W-DIGIT_W-1:0], dig_s2};
            tmo_cnt   <= '0;
            if (count == COUNT_W'(3)) begin
              data_out_q  <= {shift_reg, dig_s2};
              data_load_q <= 1'b1;
              count       <= COUNT_W'(4);
              load_cnt    <= LOAD_LAST;
              state       <= LOAD;
            end else begin
              count <= count + COUNT_W'(1);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            shift_reg <= '0;
            count     <= '0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        LOAD: begin
          if (load_cnt == '0) begin
            data_load_q <= 1'b0;
            count       <= '0;
            shift_reg   <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end else begin
            load_cnt <= load_cnt - LOAD_W'(1);
          end
        end
        default: begin
          shift_reg   <= '0;
          count       <= '0;
          data_load_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_load   = data_load_q;
  assign bus.digit_count = count;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_code_entry.sv
// tb_code_entry: directed sequence with a queue of expected codes checked on each load strobe.
// Works with or without CODE_ENTRY_DEBOUNCE_EN defined.
module tb_code_entry;
  localparam int unsigned DB  = 4;
  localparam int unsigned TMO = 200;
  localparam int unsigned LD  = 2;

`ifdef CODE_ENTRY_DEBOUNCE_EN
  localparam int unsigned GLITCH_CNT = 0;
  localparam int unsigned BOUNCE_CNT = 1;
`else
  localparam int unsigned GLITCH_CNT = 1;
  localparam int unsigned BOUNCE_CNT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_entry_if bus ();

  code_entry #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TMO),
    .LOAD_CYCLES    (LD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int loads_seen = 0;
  int loads_exp  = 0;
  logic ld_q = 1'b0;
  logic [15:0] exp_q [$];
  logic [15:0] last_code = 16'h0000;
  bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // Counts rising edges of data_load, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.data_load && !ld_q) loads_seen++;
    ld_q = bus.data_load;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic enter_partial(input logic [3:0] d, input int exp_cnt);
    bus.digit_in  = d;
    bus.digit_btn = 1'b1;
    tick(12);
    check("partial_count", 32'(bus.digit_count), 32'(exp_cnt));
    check("partial_busy", 32'(bus.busy), 32'd1);
    bus.digit_btn = 1'b0;
    tick(38);
  endtask

  task automatic press_clear();
    bus.clear_btn = 1'b1;
    tick(12);
    check("clear_count", 32'(bus.digit_count), 32'd0);
    check("clear_busy", 32'(bus.busy), 32'd0);
    bus.clear_btn = 1'b0;
    tick(20);
  endtask

  task automatic wait_load();
    int n;
    int w;
    logic [15:0] e;
    n = 0;
    while (!bus.data_load && n < 30) begin
      tick(1);
      n++;
    end
    check("load_seen", 32'(bus.data_load), 32'd1);
    if (bus.data_load) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check("data_out", 32'(bus.data_out), 32'(e));
      check("load_count4", 32'(bus.digit_count), 32'd4);
      check("load_busy", 32'(bus.busy), 32'd1);
      w = 0;
      while (bus.data_load && w < 40) begin
        w++;
        tick(1);
        if (bus.data_load) check("data_stable", 32'(bus.data_out), 32'(e));
      end
      check("load_width", 32'(w), 32'(LD));
      check("post_count", 32'(bus.digit_count), 32'd0);
      check("post_busy", 32'(bus.busy), 32'd0);
      check("post_data", 32'(bus.data_out), 32'(e));
      last_code = e;
    end
  endtask

  // Fourth digit is a short double press: the second rise lands during LOAD and must be dropped.
  task automatic enter_code(input logic [15:0] code);
    enter_partial(code[15:12], 1);
    enter_partial(code[11:8], 2);
    enter_partial(code[7:4], 3);
    exp_q.push_back(code);
    loads_exp++;
    bus.digit_in  = code[3:0];
    bus.digit_btn = 1'b1;
    tick(1);
    bus.digit_btn = 1'b0;
    tick(1);
    bus.digit_btn = 1'b1;
    wait_load();
    tick(8);
    bus.digit_btn = 1'b0;
    tick(40);
    check("after_load_count", 32'(bus.digit_count), 32'd0);
    check("loads", 32'(loads_seen), 32'(loads_exp));
  endtask

  initial begin
    rst = 1'b0;
    bus.digit_in  = 4'h0;
    bus.digit_btn = 1'b0;
    bus.clear_btn = 1'b0;
    tick(3);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_load", 32'(bus.data_load), 32'd0);
    check("rst_count", 32'(bus.digit_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    tick(5);

    // Happy path
    enter_code(16'h1476);

    // Clear mid-entry, then a fresh code
    enter_partial(4'h2, 1);
    enter_partial(4'h4, 2);
    press_clear();
    tick(20);
    check("clear_noload", 32'(loads_seen), 32'(loads_exp));
    enter_code(16'hAAAA);

    // Inter-digit timeout
    enter_partial(4'h5, 1);
    enter_partial(4'h6, 2);
    tick(TMO + 5);
    check("tmo_count", 32'(bus.digit_count), 32'd0);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    check("tmo_data", 32'(bus.data_out), 32'(last_code));
    enter_code(16'h1476);

    // Simultaneous clear and digit in COLLECT resolve to clear
    enter_partial(4'h9, 1);
    bus.digit_in  = 4'h3;
    bus.digit_btn = 1'b1;
    bus.clear_btn = 1'b1;
    tick(12);
    check("both_count", 32'(bus.digit_count), 32'd0);
    check("both_busy", 32'(bus.busy), 32'd0);
    bus.digit_btn = 1'b0;
    bus.clear_btn = 1'b0;
    tick(30);
    press_clear();
    enter_code(16'hC0DE);

    // Three-cycle glitch
    bus.digit_in  = 4'h7;
    bus.digit_btn = 1'b1;
    tick(3);
    bus.digit_btn = 1'b0;
    tick(20);
    check("glitch_count", 32'(bus.digit_count), 32'(GLITCH_CNT));
    press_clear();

    // Bouncy press settling high
    for (int i = 0; i < 6; i++) begin
      bus.digit_btn = pat[i];
      tick(1);
    end
    tick(20);
    check("bounce_count", 32'(bus.digit_count), 32'(BOUNCE_CNT));
    bus.digit_btn = 1'b0;
    tick(20);
    press_clear();
    check("bounce_loads", 32'(loads_seen), 32'(loads_exp));

    // Button held across reset release
    bus.digit_btn = 1'b1;
    tick(5);
    #3 rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(20);
    check("held_count", 32'(bus.digit_count), 32'd0);
    check("held_busy", 32'(bus.busy), 32'd0);
    bus.digit_btn = 1'b0;
    tick(20);
    check("held_release", 32'(bus.digit_count), 32'd0);
    last_code = 16'h0000;
    enter_code(16'h5A3C);

    // Asynchronous reset mid-entry
    enter_partial(4'h3, 1);
    enter_partial(4'h8, 2);
    enter_partial(4'h1, 3);
    #3 rst = 1'b0;
    #1;
    check("arst_data", 32'(bus.data_out), 32'h0);
    check("arst_load", 32'(bus.data_load), 32'd0);
    check("arst_count", 32'(bus.digit_count), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(5);
    enter_code(16'h1476);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/code_entry.md
# code_entry

Front-end entry stage for the access-control path. It assembles four 4-bit keypad digits, entered one per button press, into a 16-bit code. It then presents the code to the access-control block as a data word plus a load strobe held for a fixed number of cycles. It handles button synchronisation, optional debouncing, a clear button and an inter-digit timeout.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a filtered button level changes; legal range 1–255.
- TIMEOUT_CYCLES, 1000: idle cycles after the last accepted digit before a partial entry is discarded; legal range 2–2^20.
- LOAD_CYCLES, 2: cycles that data_load is held high per completed code; legal range 1–15.

Ports:
- clk, input, 1: system clock; all state on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- digit_in, input, 4: hex digit from switches; asynchronous to clk.
- digit_btn, input, 1: digit-enter button, active high; asynchronous, may bounce.
- clear_btn, input, 1: clear button, active high; asynchronous, may bounce.
- data_out, output, 16: last completed code; first-entered digit in [15:12].
- data_load, output, 1: load strobe to the access-control block.
- digit_count, output, 3: digits accepted in the current entry, 0–4.
- busy, output, 1: high in COLLECT or LOAD.

## Operation
- Input conditioning:
  - digit_in, digit_btn and clear_btn each pass through a 2-flop synchroniser.
  - Each button then passes through the debounce filter (see Configuration).
  - Each button then passes through a rising-edge detector, producing one-cycle pulses digit_stb and clear_stb.
  - The digit captured is the synchronised digit_in on the digit_stb cycle.
- FSM states: IDLE, COLLECT, LOAD.
  - IDLE, digit_stb: shift the digit into the low nibble of shift_reg (shift left by 4), set count=1, go to COLLECT.
  - COLLECT, digit_stb with count<3: shift in the digit, count+1, reload the timeout counter.
  - COLLECT, digit_stb with count==3: shift in the 4th digit; at the same edge, data_out <= assembled word. Then data_load=1, count=4, load counter=LOAD_CYCLES-1, go to LOAD.
  - COLLECT, clear_stb: clear shift_reg and count, go to IDLE. Clear wins over a simultaneous digit_stb, and that digit is dropped.
  - COLLECT, timeout counter reaches TIMEOUT_CYCLES-1 with no strobe: clear shift_reg and count, go to IDLE.
  - LOAD: data_load stays high; the load counter decrements each cycle. At 0, data_load=0, count=0, shift_reg=0, go to IDLE.
  - LOAD: digit_stb and clear_stb are ignored and discarded, not queued.
- IDLE: clear_stb has no effect. The timeout counter does not run.
- data_out holds its value between loads. It is never cleared except by reset.
- digit_count and busy are registered, and track the state and count above.

## Timing
- Reset (rst low, asynchronous): state=IDLE, data_out=16'h0000, data_load=0, digit_count=0, busy=0. Synchroniser, filter, edge and timeout registers also clear.
- Mid-entry or mid-LOAD reset aborts the entry immediately. After release, the first accepted press is digit 1.
- A button held high across reset release produces no strobe until it has gone low and high again.
- Latency with the macro off: a button rising before clk edge E0 is synchronised at E1. digit_stb is high between E1 and E2, and the shift and count update at E2.
- Latency with the macro on: the macro adds exactly DEBOUNCE_CYCLES edges to the off-case latency.
- data_load rises at the same edge as the 4th-digit shift. It stays high for exactly LOAD_CYCLES cycles. data_out is stable for the whole pulse.
- A digit and a clear arriving on the same cycle in COLLECT resolve to clear.
- The timeout counter is 20 bits wide and saturates; it never wraps.

## Configuration
- CODE_ENTRY_DEBOUNCE_EN defined: each synchronised button feeds a per-button 8-bit counter. The filtered level changes only after the raw level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample resets the counter.
- CODE_ENTRY_DEBOUNCE_EN undefined: the filtered level equals the synchronised level. DEBOUNCE_CYCLES is unused. No counter logic is instantiated.

## Test plan
- Happy path: press digits 1, 4, 7, 6 with clean presses, 50 cycles apart -> data_out=16'h1476, data_load high exactly 2 cycles, digit_count 1,2,3,4 then 0, busy low after LOAD.
- Clear: enter 2, 4, pulse clear, then enter A, A, A, A -> no load after the clear, digit_count=0 at the clear; then data_out=16'hAAAA with one 2-cycle load.
- Timeout: enter 5, 6 and wait TIMEOUT_CYCLES+5 cycles -> digit_count=0, busy=0, data_out unchanged. Next entry 1,4,7,6 -> 16'h1476.
- Press during LOAD: press a digit while data_load=1 -> ignored, digit_count=0 after LOAD. Clear and digit in the same cycle in COLLECT -> count=0.
- Reset mid-entry: enter 3 digits, pulse rst low asynchronously between edges -> all outputs at reset values immediately. Subsequent 1,4,7,6 loads 16'h1476.
- Bounce (macro on): 3-cycle glitch on digit_btn with DEBOUNCE_CYCLES=4 -> no strobe; a bouncy press settling high -> exactly one digit accepted. With the macro off, the same 3-cycle glitch -> one digit accepted.
